// File: rtl/param_ram_pkg.sv
// Shared defaults, sequencer state encoding and parity helper for param_ram.
package ram_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b01,
        ST_READY = 2'b10
    } state_e;

    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/param_ram_if.sv
// Access bus of param_ram; parity_err exists only with PARAM_RAM_PARITY_EN.
interface param_ram_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
);
    logic [WIDTH-1:0]  in;
    logic [WIDTH-1:0]  out;
    logic [ADDR_W-1:0] address;
    logic              load;
    logic              busy;
`ifdef PARAM_RAM_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        output in, address, load,
`ifdef PARAM_RAM_PARITY_EN
        input  parity_err,
`endif
        input  out, busy
    );

    modport slave (
        input  in, address, load,
`ifdef PARAM_RAM_PARITY_EN
        output parity_err,
`endif
        output out, busy
    );
endinterface

// File: rtl/param_ram_clear_fsm.sv
// Post-reset clear sequencer: sweeps every word to zero, then hands the
// write port to the bus.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              clr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            ST_CLEAR: begin
                // Hold at the last word rather than wrapping.
                if (&sweep_q) state_d = ST_READY;
                else          sweep_d = sweep_q + 1'b1;
            end
            ST_READY: ;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy  = 1'b1;
        we    = ~reset;
        waddr = sweep_q;
        clr   = 1'b1;
        unique case (state_q)
            ST_READY: begin
                busy  = 1'b0;
                we    = ~reset & load;
                waddr = address;
                clr   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/param_ram.sv
// Single-port RAM with post-reset clear sweep and registered write-first read.
// Optional per-word even parity with PARAM_RAM_PARITY_EN.
module param_ram
    import ram_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic clk,
    input  logic reset,
    param_ram_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef PARAM_RAM_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    logic              busy, we, clr;
    logic [ADDR_W-1:0] waddr;
    logic [MW-1:0]     wdata, rd;
    logic [WIDTH-1:0]  out_q, out_d;

    logic [MW-1:0] mem [DEPTH];

    ram_clear_fsm #(.ADDR_W(ADDR_W)) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .load    (bus.load),
        .address (bus.address),
        .busy    (busy),
        .we      (we),
        .waddr   (waddr),
        .clr     (clr)
    );

    always_comb begin
        wdata = '0;
        if (!clr) begin
            wdata[WIDTH-1:0] = bus.in;
`ifdef PARAM_RAM_PARITY_EN
            wdata[WIDTH] = even_par(64'(bus.in));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rd = mem[bus.address];

    always_comb begin
        out_d = '0;
        if (!busy) out_d = bus.load ? bus.in : rd[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

    assign bus.out  = out_q;
    assign bus.busy = busy;

`ifdef PARAM_RAM_PARITY_EN
    logic perr_q, perr_d;

    // A freshly written word is clean by construction.
    always_comb begin
        perr_d = 1'b0;
        if (!busy && !bus.load) perr_d = ^rd;
    end

    always_ff @(posedge clk) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= perr_d;
    end

    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_param_ram.sv
// Directed bench for param_ram: clear sweep, access table, mid-sweep reset.
module tb_param_ram;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    param_ram_if #(.WIDTH(16), .ADDR_W(12)) bus ();

    param_ram #(.WIDTH(16), .ADDR_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [11:0] addr;
        logic [15:0] din;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vt [17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_sweep(input string nm, input int exp_cycles);
        int n = 0;
        int nz = 0;
        while (bus.busy === 1'b1 && n < 5000) begin
            step();
            n++;
            if (bus.busy === 1'b1 && bus.out !== 16'h0) nz++;
`ifdef PARAM_RAM_PARITY_EN
            if (bus.parity_err !== 1'b0) nz++;
`endif
        end
        bus.load = 1'b0;
        check({nm, "_cycles"}, n, exp_cycles);
        check({nm, "_out0"}, nz, 0);
    endtask

    task automatic access(input logic ld, input logic [11:0] a,
                          input logic [15:0] d);
        bus.load    = ld;
        bus.address = a;
        bus.in      = d;
        step();
        bus.load    = 1'b0;
    endtask

    initial begin
        vt[0]  = '{1'b0, 12'h000, 16'h0000, 16'h0000};
        vt[1]  = '{1'b0, 12'h800, 16'h0000, 16'h0000};
        vt[2]  = '{1'b0, 12'hFFF, 16'h0000, 16'h0000};
        vt[3]  = '{1'b0, 12'h005, 16'h0000, 16'h0000};
        vt[4]  = '{1'b1, 12'h001, 16'h0001, 16'h0001};
        vt[5]  = '{1'b1, 12'h200, 16'h0003, 16'h0003};
        vt[6]  = '{1'b1, 12'h400, 16'h0007, 16'h0007};
        vt[7]  = '{1'b1, 12'hE01, 16'h00FF, 16'h00FF};
        vt[8]  = '{1'b0, 12'h001, 16'h5555, 16'h0001};
        vt[9]  = '{1'b0, 12'h200, 16'h5555, 16'h0003};
        vt[10] = '{1'b0, 12'h400, 16'h5555, 16'h0007};
        vt[11] = '{1'b0, 12'hE01, 16'h5555, 16'h00FF};
        vt[12] = '{1'b0, 12'h002, 16'h5555, 16'h0000};
        vt[13] = '{1'b1, 12'h123, 16'hBEEF, 16'hBEEF};
        vt[14] = '{1'b0, 12'h123, 16'h0000, 16'hBEEF};
        vt[15] = '{1'b1, 12'h0AA, 16'h1234, 16'h1234};
        vt[16] = '{1'b0, 12'h0AA, 16'h0000, 16'h1234};

        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.address = '0;
        bus.in      = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_busy", bus.busy, 1);
            check("rst_out", bus.out, 0);
            check("rst_sweep", dut.u_fsm.sweep_q, 0);
`ifdef PARAM_RAM_PARITY_EN
            check("rst_perr", bus.parity_err, 0);
`endif
        end
        reset = 1'b0;

        // Writes attempted during the sweep must be dropped.
        bus.load    = 1'b1;
        bus.address = 12'h005;
        bus.in      = 16'hFFFF;
        run_sweep("sweep1", 4096);
        check("ready_busy", bus.busy, 0);

        for (int i = 0; i < 17; i++) begin
            access(vt[i].load, vt[i].addr, vt[i].din);
            check($sformatf("vec%0d", i), bus.out, vt[i].exp_out);
            check($sformatf("vec%0d_busy", i), bus.busy, 0);
        end

        access(1'b1, 12'h010, 16'hABCD);
        access(1'b0, 12'h010, 16'h0000);
        check("pre_rst_word", bus.out, 16'hABCD);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rdy_rst_busy", bus.busy, 1);
        check("rdy_rst_out", bus.out, 0);
        for (int i = 0; i < 100; i++) step();
        check("mid_sweep_addr", dut.u_fsm.sweep_q, 100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_sweep", dut.u_fsm.sweep_q, 0);
        run_sweep("sweep2", 4096);

        access(1'b0, 12'h010, 16'h0000);
        check("post_rst_word", bus.out, 0);
        access(1'b0, 12'h123, 16'h0000);
        check("post_rst_beef", bus.out, 0);
        access(1'b0, 12'h005, 16'h0000);
        check("ignored_wr", bus.out, 0);

`ifdef PARAM_RAM_PARITY_EN
        access(1'b1, 12'h030, 16'h0003);
        access(1'b0, 12'h030, 16'h0000);
        check("par_clean_out", bus.out, 16'h0003);
        check("par_clean", bus.parity_err, 0);
        dut.mem[12'h030][0] = ~dut.mem[12'h030][0];
        access(1'b0, 12'h030, 16'h0000);
        check("par_flip_out", bus.out, 16'h0002);
        check("par_flip", bus.parity_err, 1);
        access(1'b0, 12'h031, 16'h0000);
        check("par_other", bus.parity_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
- REQ-001 Parameter WIDTH, default 16: data word width in bits.
- REQ-002 Parameter ADDR_W, default 12: address width; depth DEPTH = 2**ADDR_W words (default 4K).
- REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-004 Port reset, input, 1: synchronous, active-high reset.
- REQ-005 Port out, output, WIDTH: registered read data.
- REQ-006 Port in, input, WIDTH: write data.
- REQ-007 Port address, input, ADDR_W: read/write address.
- REQ-008 Port load, input, 1: write enable for the current cycle.
- REQ-009 Port busy, output, 1: high while the post-reset clear sweep runs; all accesses are ignored while it is high.

Function
- REQ-010 States: CLEAR and READY; 2-bit encoding from the shared package.
- REQ-011 In CLEAR, an internal sweep counter writes 0 to word sweep_addr each cycle, counting 0 to DEPTH-1; busy=1.
- REQ-012 CLEAR to READY on the cycle after sweep_addr = DEPTH-1 is written; sweep length is exactly DEPTH cycles; busy drops with the transition.
- REQ-013 READY is held until reset; READY never returns to CLEAR otherwise.
- REQ-014 In READY with load=1, mem[address] <= in at the rising edge.
- REQ-015 Read latency is 1 cycle: out <= mem[address] at every READY edge, regardless of load.
- REQ-016 Read-during-write to the same address is write-first: out shows the new in value one cycle later.
- REQ-017 While busy=1, load and address are ignored, and out is held at 0.
- REQ-018 The address is full-width: there is no out-of-range case, and the sweep counter does not wrap past DEPTH-1.

Reset
- REQ-019 When reset=1 at a rising edge: state <= CLEAR, sweep_addr <= 0, out <= 0, busy <= 1.
- REQ-020 Reset asserted mid-sweep restarts the sweep at address 0; reset in READY re-clears the whole array.
- REQ-021 Reset held for several cycles keeps sweep_addr at 0; the sweep begins on the first edge with reset=0.

Configuration
- REQ-022 Macro PARAM_RAM_PARITY_EN, when defined, stores 1 even-parity bit per word (^in) beside the data.
- REQ-023 With PARAM_RAM_PARITY_EN, output port parity_err (1 bit) is registered alongside out.
  - parity_err = 1 when the stored parity bit mismatches ^stored data.
  - Clear writes parity 0.
  - parity_err resets to 0 and is 0 while busy.
- REQ-024 Without PARAM_RAM_PARITY_EN: no parity storage, no parity_err port; all other behaviour is identical.

Structure
- REQ-025 Shared package/include ram_pkg holds:
  - default WIDTH and ADDR_W;
  - the CLEAR/READY state encoding;
  - the parity helper function.
- REQ-026 The clear sequencer is sub-module ram_clear_fsm, which owns state, sweep_addr and busy and drives the array write mux.
- REQ-027 The array is a single inferred memory with one write port and one synchronous read port; no per-word register instantiation.

Verification
- REQ-028 Reset pulse for 1 cycle, then idle: busy=1 for exactly 4096 cycles; afterwards a read of 0x000, 0x800 and 0xFFF returns 0x0000.
- REQ-029 Write 0x0001@0x001, 0x0003@0x200, 0x0007@0x400, 0x00FF@0xE01: readback of each address one cycle after it is presented returns the written value; unwritten 0x002 returns 0.
- REQ-030 load=1, in=0xBEEF, address=0x123, then read 0x123 on the next cycle: out=0xBEEF.
- REQ-031 Same-cycle write and read of 0x0AA with in=0x1234 (write-first): out=0x1234 one cycle later.
- REQ-032 Reset asserted at sweep cycle 100: sweep restarts at 0; busy stays high for 4096 cycles after reset deasserts; a word written before the reset reads 0.
- REQ-033 With PARAM_RAM_PARITY_EN: write 0x0003, force-flip the stored data bit 0, read: parity_err=1; a clean read gives parity_err=0; parity_err=0 throughout busy.
